// File: rtl/paper_sequencer_if.sv
// paper_sequencer_if: program-load, control and execution-unit handshake bundle.
// Rev 1.0
`default_nettype none

interface paper_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [ADDR_W+1:0] prog_data;
  logic              start;
  logic              done;
  logic              sta;
  logic [1:0]        instruct;
  logic [ADDR_W-1:0] operand;
  logic              issue;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic              err;

  modport master (
    output prog_we, prog_addr, prog_data, start, done, sta,
    input  instruct, operand, issue, pc, busy, halted, err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, done, sta,
    output instruct, operand, issue, pc, busy, halted, err
  );
endinterface

`default_nettype wire

// File: rtl/paper_sequencer.sv
// paper_sequencer: program store + PC stepping, issues opcodes to execution units.
// Rev 1.0
`default_nettype none

module paper_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 16
) (
  input wire logic         pulses,
  input wire logic         rst_n,
  paper_sequencer_if.slave bus
);
  localparam int         c_DW      = 2 + ADDR_W;
  localparam logic [1:0] c_OP_JNO  = 2'b01;
  localparam logic [1:0] c_OP_STP  = 2'b11;
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [c_DW-1:0]   r_mem [2**ADDR_W];
  logic [c_DW-1:0]   r_rdata;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_operand;
  logic [1:0]        r_instr;
  logic [7:0]        r_cnt;
  logic              r_issue;
  logic              r_busy;
  logic              r_halted;
  logic              r_err;
  logic              r_sta;
  logic              w_ready;
  logic              w_timeout;

  assign w_ready = (r_state == S_IDLE) || (r_state == S_HALT);

  // Program store: no reset, contents are whatever was last loaded.
  always_ff @(posedge pulses) begin
    if (bus.prog_we && w_ready) begin
      r_mem[bus.prog_addr] <= bus.prog_data;
    end
    r_rdata <= r_mem[r_pc];
  end

  always_ff @(posedge pulses or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE, S_HALT: if (bus.start) w_next = S_FETCH;
      S_FETCH:        w_next = S_ISSUE;
      S_ISSUE:        w_next = (r_rdata[c_DW-1 -: 2] == c_OP_STP) ? S_HALT : S_WAIT;
      S_WAIT: begin
        // A done on the final counted cycle still wins over the timeout.
        if (bus.done) begin
          w_next = S_UPDATE;
        end else if (r_cnt == c_TO_LAST) begin
          w_next    = S_HALT;
          w_timeout = 1'b1;
        end
      end
      S_UPDATE:       w_next = S_FETCH;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pulses or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_instr   <= 2'b00;
      r_operand <= '0;
      r_cnt     <= 8'd0;
      r_issue   <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_err     <= 1'b0;
      r_sta     <= 1'b0;
    end else begin
      r_issue  <= (w_next == S_WAIT);
      r_busy   <= (w_next == S_FETCH) || (w_next == S_ISSUE) ||
                  (w_next == S_WAIT)  || (w_next == S_UPDATE);
      r_halted <= (w_next == S_HALT);
      r_cnt    <= (r_state == S_WAIT) ? r_cnt + 8'd1 : 8'd0;

      if (w_ready && bus.start) begin
        r_pc  <= '0;
        r_err <= 1'b0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state == S_ISSUE) begin
        r_instr   <= r_rdata[c_DW-1 -: 2];
        r_operand <= r_rdata[ADDR_W-1:0];
      end
      if ((r_state == S_WAIT) && bus.done) begin
        r_sta <= bus.sta;
      end
      if (r_state == S_UPDATE) begin
        r_pc <= ((r_instr == c_OP_JNO) && !r_sta) ? r_operand : r_pc + 1'b1;
      end
    end
  end

  assign bus.instruct = r_instr;
  assign bus.operand  = r_operand;
  assign bus.issue    = r_issue;
  assign bus.pc       = r_pc;
  assign bus.busy     = r_busy;
  assign bus.halted   = r_halted;
  assign bus.err      = r_err;
endmodule

`default_nettype wire

// File: tb/tb_paper_sequencer.sv
// tb_paper_sequencer: directed self-checking bench for paper_sequencer.
// Rev 1.0
`default_nettype none

module tb_paper_sequencer;
  logic pulses = 1'b0;
  logic rst_n  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  paper_sequencer_if #(.ADDR_W(4)) bus ();

  paper_sequencer #(.ADDR_W(4), .TIMEOUT(16)) dut (
    .pulses (pulses),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  always #5 pulses = ~pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [3:0] addr, input logic [5:0] data);
    @(negedge pulses);
    bus.prog_we = 1'b1; bus.prog_addr = addr; bus.prog_data = data;
    @(negedge pulses);
    bus.prog_we = 1'b0;
  endtask

  task automatic do_start(input string tag);
    @(negedge pulses);
    bus.start = 1'b1;
    @(negedge pulses);
    bus.start = 1'b0;
    check({tag, "_busy"},   32'(bus.busy),   32'd1);
    check({tag, "_halted"}, 32'(bus.halted), 32'd0);
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!bus.issue && n < 40) begin
      @(negedge pulses);
      n++;
    end
    check(tag, 32'(bus.issue), 32'd1);
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!bus.halted && n < 40) begin
      @(negedge pulses);
      n++;
    end
    check(tag, 32'(bus.halted), 32'd1);
  endtask

  // Waits for issue, checks the issued word, then returns done one cycle later.
  task automatic run_instr(input logic sta_v, input string tag, input logic [1:0] exp_op,
                           input logic [3:0] exp_opd, input logic [3:0] exp_pc);
    wait_issue({tag, "_issue"});
    check({tag, "_op"},  32'(bus.instruct), 32'(exp_op));
    check({tag, "_opd"}, 32'(bus.operand),  32'(exp_opd));
    check({tag, "_pc"},  32'(bus.pc),       32'(exp_pc));
    @(negedge pulses);
    bus.done = 1'b1; bus.sta = sta_v;
    @(negedge pulses);
    bus.done = 1'b0; bus.sta = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"},  32'(bus.instruct), 32'd0);
    check({tag, "_opd"},    32'(bus.operand),  32'd0);
    check({tag, "_issue"},  32'(bus.issue),    32'd0);
    check({tag, "_pc"},     32'(bus.pc),       32'd0);
    check({tag, "_busy"},   32'(bus.busy),     32'd0);
    check({tag, "_halted"}, 32'(bus.halted),   32'd0);
    check({tag, "_err"},    32'(bus.err),      32'd0);
  endtask

  initial begin
    int cnt;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.done = 1'b0; bus.sta = 1'b0;
    repeat (2) @(negedge pulses);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // INC 3, DEC 2, STP with start-to-issue latency.
    load(4'd0, 6'b00_0011);
    load(4'd1, 6'b10_0010);
    load(4'd2, 6'b11_0000);
    do_start("t1_start");
    @(negedge pulses);
    check("t1_lat_issue_p2", 32'(bus.issue), 32'd0);
    @(negedge pulses);
    check("t1_lat_issue_p3", 32'(bus.issue), 32'd1);
    run_instr(1'b0, "t1_i0", 2'b00, 4'd3, 4'd0);
    run_instr(1'b1, "t1_i1", 2'b10, 4'd2, 4'd1);
    wait_halt("t1_halt");
    check("t1_pc",    32'(bus.pc),    32'd2);
    check("t1_err",   32'(bus.err),   32'd0);
    check("t1_issue", 32'(bus.issue), 32'd0);

    // JNO taken (sta=0) then not taken (sta=1).
    load(4'd0, 6'b01_0101);
    load(4'd5, 6'b11_0000);
    do_start("t2a_start");
    run_instr(1'b0, "t2a_jno", 2'b01, 4'd5, 4'd0);
    wait_halt("t2a_halt");
    check("t2a_pc", 32'(bus.pc), 32'd5);
    do_start("t2b_start");
    run_instr(1'b1, "t2b_jno", 2'b01, 4'd5, 4'd0);
    run_instr(1'b0, "t2b_dec", 2'b10, 4'd2, 4'd1);
    wait_halt("t2b_halt");
    check("t2b_pc", 32'(bus.pc), 32'd2);

    // All INC: PC wraps 15 -> 0, then that instruction times out.
    for (int i = 0; i < 16; i++) load(4'(i), {2'b00, 4'(i)});
    do_start("t3_start");
    for (int i = 0; i < 16; i++) run_instr(1'b0, $sformatf("t3_i%0d", i), 2'b00, 4'(i), 4'(i));
    wait_issue("t3_wrap_issue");
    check("t3_wrap_pc",  32'(bus.pc),      32'd0);
    check("t3_wrap_opd", 32'(bus.operand), 32'd0);
    cnt = 0;
    while (bus.issue && cnt < 40) begin
      cnt++;
      @(negedge pulses);
    end
    check("t4_issue_cycles", 32'(cnt),        32'd16);
    check("t4_err",          32'(bus.err),    32'd1);
    check("t4_halted",       32'(bus.halted), 32'd1);
    check("t4_issue_low",    32'(bus.issue),  32'd0);
    do_start("t4_restart");
    check("t4_err_cleared", 32'(bus.err), 32'd0);

    // Async reset mid-WAIT.
    run_instr(1'b0, "t5_i0", 2'b00, 4'd0, 4'd0);
    run_instr(1'b0, "t5_i1", 2'b00, 4'd1, 4'd1);
    wait_issue("t5_pre_issue");
    check("t5_pre_opd", 32'(bus.operand), 32'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_async");
    @(negedge pulses);
    rst_n = 1'b1;
    do_start("t5_start");
    run_instr(1'b0, "t5_re0", 2'b00, 4'd0, 4'd0);

    // Writes during execution are ignored; a write coincident with start lands.
    @(negedge pulses);
    rst_n = 1'b0;
    @(negedge pulses);
    rst_n = 1'b1;
    load(4'd1, 6'b10_1001);
    load(4'd2, 6'b11_0000);
    @(negedge pulses);
    bus.start = 1'b1; bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = 6'b00_0111;
    @(negedge pulses);
    bus.start = 1'b0; bus.prog_addr = 4'd1; bus.prog_data = 6'b11_0000;
    run_instr(1'b0, "t6_i0", 2'b00, 4'd7, 4'd0);
    run_instr(1'b0, "t6_i1", 2'b10, 4'd9, 4'd1);
    bus.prog_we = 1'b0;
    wait_halt("t6_halt");
    check("t6_pc", 32'(bus.pc), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/paper_sequencer.md
# paper_sequencer

Instruction issuer for the paper processor. It holds a small program store and steps a program counter through it. For each instruction it drives the 2-bit `instruct` code and an issue strobe to the execution units (INC/DEC register units and the JNO check unit), then waits for their completion handshake. It samples the status flag `sta` to resolve JNO branches and stops on STP or on an execution-unit timeout.

## Interface
- `ADDR_W`, 4: program address width; depth = 2^ADDR_W words.
- `TIMEOUT`, 16: max cycles waiting for `done` before error (range 2..255).
- `pulses`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `prog_we`  in  1  program-store write strobe; ignored unless in IDLE or HALT.
- `prog_addr`  in  ADDR_W  program-store write address.
- `prog_data`  in  2+ADDR_W  {opcode[1:0], operand[ADDR_W-1:0]}.
- `start`  in  1  begin execution at address 0; level sampled in IDLE/HALT.
- `done`  in  1  execution unit finished the current instruction (1-cycle pulse or level).
- `sta`  in  1  status from executing unit; valid in the cycle `done`=1.
- `instruct`  out  2  opcode of the issued instruction.
- `operand`  out  ADDR_W  operand field of the issued instruction.
- `issue`  out  1  instruction valid; held until `done`.
- `pc`  out  ADDR_W  current program counter.
- `busy`  out  1  high in FETCH/ISSUE/WAIT/UPDATE.
- `halted`  out  1  high in HALT.
- `err`  out  1  sticky timeout flag; cleared on `start` or reset.

## Operation
- Opcodes: 00 INC (operand = register), 01 JNO (operand = target), 10 DEC (operand = register), 11 STP.
- The program store is 2^ADDR_W x (2+ADDR_W) with a synchronous write and a registered read. Its contents are undefined after reset (not cleared).
- States:
  - IDLE: wait for `start`. Goes to FETCH with `pc`=0 and `err` cleared.
  - FETCH: read the word at `pc`. Goes to ISSUE.
  - ISSUE: register `instruct`/`operand` from the read word.
    - STP goes to HALT; no issue.
    - Otherwise assert `issue` and go to WAIT.
  - WAIT: hold `issue`=1 and the outputs stable, and count cycles.
    - On `done`=1, capture `sta` and go to UPDATE.
    - When the count reaches TIMEOUT without `done`, set `err` and go to HALT.
  - UPDATE: drop `issue` and compute the next `pc`. Goes to FETCH.
    - JNO with captured `sta`=0: `pc` <= operand.
    - JNO with `sta`=1: `pc` <= `pc`+1.
    - INC/DEC: `pc` <= `pc`+1, ignoring `sta`.
  - HALT: hold `pc`. `start` restarts at 0 via FETCH with `err` cleared.
- `pc`+1 wraps modulo 2^ADDR_W (last address +1 is 0). A JNO to its own address is legal and loops.
- `done` outside WAIT is ignored.
- `prog_we` is ignored while `busy`=1.
- If `start` and `prog_we` are both high in IDLE, the write takes effect and execution starts next cycle. Fetch of address 0 sees the new data if `prog_addr`=0.

## Timing
- Reset (async, immediate): state IDLE, `pc`=0, `instruct`=00, `operand`=0, `issue`=0, `busy`=0, `halted`=0, `err`=0, wait counter=0.
- Reset asserted mid-WAIT drops `issue` immediately. No completion is recorded.
- Latency from `start` sampled in IDLE:
  - FETCH at +1, ISSUE at +2.
  - `issue` is high from +3, in the first WAIT cycle.
- Per instruction: `done` seen in cycle N means UPDATE at N+1, FETCH at N+2, next `issue` at N+4.
- The minimum instruction period is 4 cycles, with `done` in the first WAIT cycle.
- Timeout: if `done` is absent for TIMEOUT consecutive WAIT cycles, `err`=1 and `halted`=1 in the next cycle.
- `done` arriving on the same edge the count reaches TIMEOUT counts as completion; no error.
- `halted` and `err` are registered outputs. `halted` stays 1 until `start` or reset.

## Test plan
- Load {INC 3, DEC 2, STP}, `start`, return `done` 1 cycle after each `issue`. Required:
  - `instruct` sequence 00, 10 with operands 3, 2.
  - `halted`=1 with `pc`=2.
  - `err`=0.
- Load addr0 = JNO 5, addr5 = STP; `done` with `sta`=0. Required: `pc` goes 0 to 5, then `halted`. Repeat with `sta`=1: `pc` goes to 1.
- Wrap (ADDR_W=4): fill addresses 0..15 with INC, set `pc` to 15, complete the instruction. Required: next fetch at `pc`=0.
- Timeout (TIMEOUT=16): issue INC and never assert `done`. Required:
  - `issue` held for exactly 16 cycles.
  - Then `err`=1, `halted`=1, `issue`=0.
  - `start` clears `err`.
- Assert `rst_n`=0 mid-WAIT. Required:
  - All outputs take their reset values asynchronously.
  - After release and `start`, the program restarts at 0.
- `prog_we` pulses while `busy`: the program store is unchanged. Read-back via execution matches the original program.
